// File: rtl/alu_wide_seq.sv
// Multi-word add/subtract sequencer driving an external 16-bit combinational ALU.
// One word per cycle, least-significant first, with ALU carry chained back into CI.
package alu_wide_pkg;
    typedef enum logic [1:0] {
        kADD = 2'b00,
        kSUB = 2'b01,
        kAND = 2'b10,
        kOR  = 2'b11
    } alu_op_e;
endpackage

module alu_wide_seq
    import alu_wide_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                sub_i,
    input  logic [16*WORDS-1:0] opa_i,
    input  logic [16*WORDS-1:0] opb_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [16*WORDS-1:0] result_o,
    output logic                carry_out_o,
    output logic                zero_o,
    output logic                overflow_o,
    output logic [1:0]          alu_op_o,
    output logic [15:0]         alu_a_o,
    output logic [15:0]         alu_b_o,
    output logic                alu_ci_o,
    input  logic [15:0]         alu_out_i,
    input  logic                alu_co_i
);

    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [WORDS-1:0][15:0]  a_q, b_q, res_q;
    logic                    sub_q;
    logic [IDXW-1:0]         idx_q;
    logic                    carry_q;
    logic                    zacc_q;
    logic                    cout_q, zero_q, ovf_q;
    logic                    last_word;
    logic                    out_zero;

    assign last_word = (idx_q == IDXW'(WORDS - 1));
    assign out_zero  = (alu_out_i == 16'h0000);

    assign alu_op_o    = kADD;
    assign result_o    = res_q;
    assign carry_out_o = cout_q;
    assign zero_o      = zero_q;
    assign overflow_o  = ovf_q;

    // Subtraction is A + ~B + 1: B is inverted here, the +1 is the seeded carry.
    always_comb begin
        state_d  = state_q;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        alu_a_o  = 16'h0000;
        alu_b_o  = 16'h0000;
        alu_ci_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                busy_o   = 1'b1;
                alu_a_o  = a_q[idx_q];
                alu_b_o  = sub_q ? ~b_q[idx_q] : b_q[idx_q];
                alu_ci_o = carry_q;
                if (last_word) state_d = S_FIN;
            end
            S_FIN: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q     <= opa_i;
                        b_q     <= opb_i;
                        sub_q   <= sub_i;
                        idx_q   <= '0;
                        carry_q <= sub_i;
                        zacc_q  <= 1'b1;
                        res_q   <= '0;
                        cout_q  <= 1'b0;
                        zero_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    res_q[idx_q] <= alu_out_i;
                    carry_q      <= alu_co_i;
                    zacc_q       <= zacc_q & out_zero;
                    if (last_word) begin
                        // Signed overflow judged on the top word's sign bits as fed to the ALU.
                        ovf_q  <= (alu_a_o[15] == alu_b_o[15]) && (alu_out_i[15] != alu_a_o[15]);
                        cout_q <= alu_co_i;
                        zero_q <= zacc_q & out_zero;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Self-checking bench for alu_wide_seq: table vectors, random ops against a
// whole-width arithmetic model, plus restart-ignore and reset-abort sequences.
module tb_alu_wide_seq;
    import alu_wide_pkg::*;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;
    localparam int LAT   = WORDS + 1;

    logic         clk, rst, start, sub;
    logic [W-1:0] opa, opb, result;
    logic         busy, done, carry_out, zero, overflow;
    logic [1:0]   alu_op;
    logic [15:0]  alu_a, alu_b, alu_out;
    logic         alu_ci, alu_co;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  c1_op;
    logic [15:0] c1_b;
    logic        c1_ci;

    alu_wide_seq #(.WORDS(WORDS)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .sub_i(sub),
        .opa_i(opa), .opb_i(opb), .busy_o(busy), .done_o(done),
        .result_o(result), .carry_out_o(carry_out), .zero_o(zero),
        .overflow_o(overflow), .alu_op_o(alu_op), .alu_a_o(alu_a),
        .alu_b_o(alu_b), .alu_ci_o(alu_ci), .alu_out_i(alu_out),
        .alu_co_i(alu_co)
    );

    // The ALU on the far side: only kADD does arithmetic; anything else yields junk.
    always_comb begin
        if (alu_op == kADD) {alu_co, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_ci};
        else                {alu_co, alu_out} = {1'b0, alu_a ^ alu_b};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] r, output logic c, output logic z,
                                  output logic o);
        logic [W:0] sum;
        if (!s) begin
            sum = {1'b0, a} + {1'b0, b};
            r = sum[W-1:0];
            c = sum[W];
            o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r = a - b;
            c = (a >= b);
            o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
        z = (r == '0);
    endfunction

    // Issue one op and follow it to DONE (bounded); scrambles inputs after the START edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] r, output logic c, output logic z,
                          output logic o, output int lat, output bit busy_ok);
        @(negedge clk);
        opa = a; opb = b; sub = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        opa = {$urandom, $urandom};
        opb = {$urandom, $urandom};
        sub = 1'($urandom);
        lat = -1; busy_ok = 1'b1;
        r = '0; c = 1'b0; z = 1'b0; o = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                c1_op = alu_op; c1_b = alu_b; c1_ci = alu_ci;
            end
            if (busy !== (cyc <= LAT)) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = cyc;
                r = result; c = carry_out; z = zero; o = overflow;
                break;
            end
        end
    endtask

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] er;
        logic         ec;
        logic         ez;
        logic         eo;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [W-1:0] r, mr;
        logic         c, z, o, mc, mz, mo;
        int           lat;
        bit           bok;
        bit           saw_done;

        vecs[0] = '{"add_ffff_p1",  64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"add_allones",  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0,                   1'b1, 1'b1, 1'b0};
        vecs[2] = '{"sub_4_4",      64'h4,                   64'h4, 1'b1, 64'h0,                   1'b1, 1'b1, 1'b0};
        vecs[3] = '{"sub_0_1",      64'h0,                   64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"add_maxpos",   64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{"sub_minneg",   64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; sub = 1'b0; opa = '0; opb = '0;
        #12;
        chk("rst_busy", W'(busy), 0);
        chk("rst_done", W'(done), 0);
        chk("rst_result", result, 0);
        chk("rst_flags", W'({carry_out, zero, overflow}), 0);
        chk("rst_alu_abci", W'({alu_a, alu_b, alu_ci}), 0);
        chk("rst_alu_op", W'(alu_op), W'(kADD));
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, r, c, z, o, lat, bok);
            chk({vecs[i].name, "_lat"}, W'(lat), W'(LAT));
            chk({vecs[i].name, "_busy"}, W'(bok), 1);
            chk({vecs[i].name, "_result"}, r, vecs[i].er);
            chk({vecs[i].name, "_cfz"}, W'({c, z, o}), W'({vecs[i].ec, vecs[i].ez, vecs[i].eo}));
            if (i == 2) begin
                chk("sub_c1_op", W'(c1_op), W'(kADD));
                chk("sub_c1_b", W'(c1_b), 64'hFFFB);
                chk("sub_c1_ci", W'(c1_ci), 1);
            end
            @(negedge clk);
            chk({vecs[i].name, "_done_1cyc"}, W'({done, busy}), 0);
            chk({vecs[i].name, "_held"}, result, vecs[i].er);
        end

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] a, b;
            logic s;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (n % 8 == 1) b = a;
            if (n % 8 == 3) a = ~b + 64'(n & 1);
            s = 1'($urandom);
            model(a, b, s, mr, mc, mz, mo);
            run_op(a, b, s, r, c, z, o, lat, bok);
            chk("rnd_lat", W'(lat), W'(LAT));
            chk("rnd_result", r, mr);
            chk("rnd_cfz", W'({c, z, o}), W'({mc, mz, mo}));
        end

        // START re-pulsed mid-run with different operands must be ignored.
        @(negedge clk);
        opa = 64'h0123_4567_89AB_CDEF; opb = 64'h1111_1111_1111_1111; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                start = 1'b1; opa = '1; opb = 64'h5; sub = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        chk("restart_lat", W'(lat), W'(LAT));
        chk("restart_result", result, 64'h1234_5678_9ABC_DF00);
        start = 1'b0;
        @(negedge clk);
        chk("restart_no_requeue", W'(busy), 0);

        // Asynchronous reset in cycle 3 aborts the operation without a DONE.
        @(negedge clk);
        opa = 64'h0001_0002_0003_0004; opb = 64'h0010_0020_0030_0040; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_partial", W'(result != '0), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", W'(busy), 0);
        chk("abort_result", result, 0);
        chk("abort_alu", W'({alu_a, alu_b, alu_ci}), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", W'(saw_done), 0);
        run_op(64'h5, 64'h3, 1'b0, r, c, z, o, lat, bok);
        chk("after_abort_lat", W'(lat), W'(LAT));
        chk("after_abort_result", r, 64'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_wide_seq.md
Name: alu_wide_seq

Overview:
- Multi-word arithmetic sequencer. It is the controller on the other side of the ALU interface: it drives ALU operands, OP and CI, and consumes the ALU's OUT and CO.
- Performs WORDS×16-bit add or subtract by issuing one 16-bit kADD per cycle, least-significant word first, chaining ALU CO back into CI.
- Sits between the control unit, which issues START/SUB and the wide operands, and the existing combinational ALU.

Parameters:
- WORDS, 4, number of 16-bit words per operand (result width 16*WORDS); legal range 1..16.

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- SUB  input  1  0 = A+B, 1 = A-B; latched with START.
- OPA  input  16*WORDS  operand A; latched with START.
- OPB  input  16*WORDS  operand B; latched with START.
- BUSY  output  1  high in RUN and FIN.
- DONE  output  1  one-cycle pulse; result valid.
- RESULT  output  16*WORDS  final sum/difference; held until the next accepted START.
- CARRY_OUT  output  1  final carry (for SUB: 1 = no borrow).
- ZERO  output  1  RESULT is all zeros.
- OVERFLOW  output  1  two's-complement signed overflow of the full-width operation.
- ALU_OP  output  2  always kADD from the definitions package.
- ALU_A  output  16  current A word.
- ALU_B  output  16  current B word (inverted when SUB).
- ALU_CI  output  1  carry into the current word.
- ALU_OUT  input  16  ALU result (combinational, same cycle).
- ALU_CO  input  1  ALU carry out.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - BUSY, DONE, CARRY_OUT, ZERO, OVERFLOW = 0; RESULT = 0; internal operand registers, word index and carry register = 0.
  - ALU_A, ALU_B, ALU_CI = 0; ALU_OP = kADD.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - ALU_A, ALU_B, ALU_CI driven to 0.
  - START=1 at a rising edge: latch OPA, OPB, SUB; idx <= 0; carry <= SUB; zero accumulator <= 1; clear RESULT, CARRY_OUT, ZERO and OVERFLOW; go to RUN.
- RUN, cycle k (k = 0..WORDS-1):
  - ALU_A = A word k; ALU_B = SUB ? ~B word k : B word k; ALU_CI = carry register.
  - At the edge: RESULT word k <= ALU_OUT; carry <= ALU_CO; zero accumulator &= (ALU_OUT == 0).
  - On the last word (idx == WORDS-1): OVERFLOW <= (ALU_A[15] == ALU_B[15]) && (ALU_OUT[15] != ALU_A[15]); CARRY_OUT <= ALU_CO; ZERO <= final zero accumulator; go to FIN. Otherwise idx <= idx + 1.
- Subtraction is A + ~B + 1. The +1 comes from the initial carry = 1; the block never issues kSUB.
- FIN: DONE = 1 for exactly this cycle; BUSY = 1; next state IDLE.
- Latency: with START accepted at edge 0, RUN occupies cycles 1..WORDS and DONE is high in cycle WORDS+1. Throughput is one operation per WORDS+2 cycles; back-to-back START is accepted in the cycle after FIN.
- START while BUSY is ignored: no queueing, latched operands unchanged.
- OPA, OPB and SUB may change freely after the START edge without affecting the result.
- RESET mid-operation aborts immediately. No DONE is produced and all outputs return to their reset values.
- WORDS = 1 degenerates to one RUN cycle; DONE in cycle 2.

Test Plan:
- WORDS=4, ADD 0x0000_0000_0000_FFFF + 0x1 -> RESULT 0x0000_0000_0001_0000, CARRY_OUT=0, ZERO=0, OVERFLOW=0; DONE high exactly in cycle 5, BUSY high cycles 1-5.
- ADD 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> RESULT 0, CARRY_OUT=1, ZERO=1, OVERFLOW=0.
- SUB 0x4 - 0x4 -> RESULT 0, ZERO=1, CARRY_OUT=1; during RUN cycle 1, check ALU_OP=kADD, ALU_B=0xFFFB, ALU_CI=1.
- SUB 0x0 - 0x1 -> RESULT 0xFFFF_FFFF_FFFF_FFFF, CARRY_OUT=0, OVERFLOW=0.
- ADD 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> RESULT 0x8000_0000_0000_0000, OVERFLOW=1.
- START re-pulsed with new operands in cycle 2 -> ignored, original result delivered. Separately, RESET asserted in cycle 3 -> BUSY=0 and RESULT=0 asynchronously, no DONE pulse; the next START completes normally.
